ip_rule_matcher: RTL and testbench
==================================

IP_RULE_MATCHER -- requirements
Module: ip_rule_matcher

Interface
REQ-001 SHALL have parameter NUM_RULES, default 16: number of rule-table entries (power of two, 2..64).
REQ-002 SHALL have parameter DEFAULT_DROP, default 0: action applied when no rule matches (1 = drop).
REQ-003 SHALL have port clk  input  1  system clock; single clock domain.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port src_ip  input  32  source IPv4 address from the upstream parser.
REQ-006 SHALL have port dst_ip  input  32  destination IPv4 address from the upstream parser.
REQ-007 SHALL have port ip_valid  input  1  address-valid level from the upstream parser; may stay high for many cycles.
REQ-008 SHALL have port cfg_we  input  1  rule-table write strobe.
REQ-009 SHALL have port cfg_addr  input  $clog2(NUM_RULES)  rule index to write.
REQ-010 SHALL have port cfg_en, cfg_dir, cfg_drop  input  1 each  rule enable; field select (0 = src, 1 = dst); rule action (1 = drop).
REQ-011 SHALL have port cfg_ip, cfg_mask  input  32 each  rule address and prefix mask.
REQ-012 SHALL have port busy  output  1  high while a lookup is in progress.
REQ-013 SHALL have port dec_valid  output  1  one-cycle pulse, decision available.
REQ-014 SHALL have port dec_drop, dec_hit  output  1 each  decision (1 = drop); a rule matched.
REQ-015 SHALL have port dec_idx  output  $clog2(NUM_RULES)  index of the matching rule; 0 when dec_hit = 0.
REQ-016 SHALL have port missed_cnt  output  8  count of lookups lost because the block was busy.
REQ-017 SHALL have port pkt_cnt, drop_cnt  output  16 each  statistics counters (see Configuration).

Function
REQ-018 SHALL start a lookup on the rising edge of ip_valid only (ip_valid = 1 and the registered previous value = 0); a held-high ip_valid SHALL NOT retrigger.
REQ-019 SHALL latch src_ip and dst_ip in the trigger cycle; later input changes SHALL NOT affect that lookup.
REQ-020 SHALL implement FSM IDLE -> SCAN -> RESULT -> IDLE; busy = 1 in SCAN and RESULT.
REQ-021 SHALL, in SCAN, evaluate one rule per cycle starting at index 0: a rule matches when it is enabled and ((selected_ip XOR rule_ip) AND rule_mask) == 0.
REQ-022 SHALL apply first-match priority (lowest index wins) and leave SCAN on the first match.
REQ-023 SHALL, after evaluating index NUM_RULES-1 without a match, enter RESULT with dec_hit = 0, dec_drop = DEFAULT_DROP, and dec_idx = 0.
REQ-024 SHALL assert dec_valid for exactly the RESULT cycle: trigger at cycle T with a hit at index k gives dec_valid at T+k+2; a miss gives dec_valid at T+NUM_RULES+1.
REQ-025 SHALL hold dec_drop, dec_hit, and dec_idx stable from RESULT until the next RESULT.
REQ-026 SHALL, on an ip_valid rising edge while busy = 1, ignore the lookup and increment missed_cnt, saturating at 255.
REQ-027 SHALL commit a cfg_we write at the clock edge; writes during SCAN are permitted and are visible to rules not yet evaluated.
REQ-028 SHALL treat a mask of 0 as match-all and a mask of 32'hFFFFFFFF as exact match.

Reset
REQ-029 SHALL, on rst = 1, return to IDLE and clear busy, dec_valid, dec_drop, dec_hit, dec_idx, missed_cnt, pkt_cnt, drop_cnt, the latched addresses, and the edge-detect register to 0.
REQ-030 SHALL clear every rule's enable bit on reset; rule address and mask contents may be left unreset.
REQ-031 SHALL, on reset mid-SCAN, abort the lookup and produce no dec_valid pulse.

Configuration
REQ-032 SHALL, when IP_RULE_STATS_EN is defined, increment pkt_cnt on every dec_valid and drop_cnt on every dec_valid with dec_drop = 1; both counters saturate at 16'hFFFF.
REQ-033 SHALL, when IP_RULE_STATS_EN is undefined, drive pkt_cnt and drop_cnt constant 0 and include no counter logic.

Verification
REQ-034 SHALL cover the exact hit: rule 3 = {en, src, drop, 10.0.0.5, /32}, src_ip = 10.0.0.5, ip_valid rises at T -> dec_valid at T+5, dec_hit = 1, dec_idx = 3, dec_drop = 1.
REQ-035 SHALL cover prefix and priority: rule 1 = {dst, allow, 192.168.0.0, /16}, rule 2 = {dst, drop, 192.168.1.0, /24}, dst_ip = 192.168.1.9 -> dec_idx = 1, dec_drop = 0.
REQ-036 SHALL cover the miss: all rules disabled, DEFAULT_DROP = 1, NUM_RULES = 16, trigger at T -> dec_valid at T+17, dec_hit = 0, dec_drop = 1.
REQ-037 SHALL cover the busy collision: a second ip_valid rising edge 3 cycles after the first -> missed_cnt = 1 and exactly one dec_valid pulse.
REQ-038 SHALL cover held-high ip_valid: ip_valid held high for 40 cycles -> exactly one lookup and one dec_valid pulse.
REQ-039 SHALL cover reset mid-scan: rst asserted at T+4 of a miss lookup -> no dec_valid pulse, busy = 0, all rules disabled.

Source files
------------

// File: rtl/ip_rule_matcher.sv
// rtl/ip_rule_matcher.sv - first-match IPv4 rule scanner, one rule evaluated per cycle
// Optional statistics counters are built in when IP_RULE_STATS_EN is defined.
module ip_rule_matcher #(
  parameter int NUM_RULES    = 16,
  parameter bit DEFAULT_DROP = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  src_ip,
  input  logic [31:0]                  dst_ip,
  input  logic                         ip_valid,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_RULES)-1:0] cfg_addr,
  input  logic                         cfg_en,
  input  logic                         cfg_dir,
  input  logic                         cfg_drop,
  input  logic [31:0]                  cfg_ip,
  input  logic [31:0]                  cfg_mask,
  output logic                         busy,
  output logic                         dec_valid,
  output logic                         dec_drop,
  output logic                         dec_hit,
  output logic [$clog2(NUM_RULES)-1:0] dec_idx,
  output logic [7:0]                   missed_cnt,
  output logic [15:0]                  pkt_cnt,
  output logic [15:0]                  drop_cnt
);

  localparam int IDX_W = $clog2(NUM_RULES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RULES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, RESULT} state_t;
  state_t state, next_state;

  logic [NUM_RULES-1:0] rule_en;
  logic [NUM_RULES-1:0] rule_dir;
  logic [NUM_RULES-1:0] rule_drop;
  logic [31:0]          rule_ip   [NUM_RULES];
  logic [31:0]          rule_mask [NUM_RULES];

  logic             ip_valid_q;
  logic [31:0]      src_lat;
  logic [31:0]      dst_lat;
  logic [IDX_W-1:0] scan_idx;

  logic        rise;
  logic        start;
  logic        match;
  logic        last;
  logic [31:0] sel_ip;

  assign rise  = ip_valid & ~ip_valid_q;
  assign start = rise && (state == IDLE);
  assign last  = (scan_idx == LAST_IDX);

  // Table reads are combinational, so a write committed mid-scan is seen by later indices.
  assign sel_ip = rule_dir[scan_idx] ? dst_lat : src_lat;
  assign match  = rule_en[scan_idx] &&
                  (((sel_ip ^ rule_ip[scan_idx]) & rule_mask[scan_idx]) == 32'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      rule_en <= '0;
    end else if (cfg_we) begin
      rule_en[cfg_addr] <= cfg_en;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_we) begin
      rule_dir[cfg_addr]  <= cfg_dir;
      rule_drop[cfg_addr] <= cfg_drop;
      rule_ip[cfg_addr]   <= cfg_ip;
      rule_mask[cfg_addr] <= cfg_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    dec_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (match || last) next_state = RESULT;
      end
      RESULT: begin
        busy       = 1'b1;
        dec_valid  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ip_valid_q <= 1'b0;
      src_lat    <= '0;
      dst_lat    <= '0;
      scan_idx   <= '0;
      dec_hit    <= 1'b0;
      dec_drop   <= 1'b0;
      dec_idx    <= '0;
      missed_cnt <= '0;
    end else begin
      ip_valid_q <= ip_valid;
      if (start) begin
        src_lat  <= src_ip;
        dst_lat  <= dst_ip;
        scan_idx <= '0;
      end
      if (state == SCAN) begin
        if (match || last) begin
          dec_hit  <= match;
          dec_drop <= match ? rule_drop[scan_idx] : DEFAULT_DROP;
          dec_idx  <= match ? scan_idx : '0;
        end else begin
          scan_idx <= scan_idx + IDX_W'(1);
        end
      end
      if (rise && (state != IDLE) && (missed_cnt != 8'hFF)) begin
        missed_cnt <= missed_cnt + 8'd1;
      end
    end
  end

`ifdef IP_RULE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else if (dec_valid) begin
      if (pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
      if (dec_drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  assign pkt_cnt  = 16'd0;
  assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_ip_rule_matcher.sv
// tb/tb_ip_rule_matcher.sv - scoreboard bench for ip_rule_matcher (NUM_RULES=16, DEFAULT_DROP=1)
module tb_ip_rule_matcher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] src_ip = '0;
  logic [31:0] dst_ip = '0;
  logic        ip_valid = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic        cfg_en = 1'b0;
  logic        cfg_dir = 1'b0;
  logic        cfg_drop = 1'b0;
  logic [31:0] cfg_ip = '0;
  logic [31:0] cfg_mask = '0;
  logic        busy;
  logic        dec_valid;
  logic        dec_drop;
  logic        dec_hit;
  logic [3:0]  dec_idx;
  logic [7:0]  missed_cnt;
  logic [15:0] pkt_cnt;
  logic [15:0] drop_cnt;

  ip_rule_matcher #(.NUM_RULES(16), .DEFAULT_DROP(1'b1)) dut (
    .clk(clk), .rst(rst), .src_ip(src_ip), .dst_ip(dst_ip), .ip_valid(ip_valid),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_en(cfg_en), .cfg_dir(cfg_dir),
    .cfg_drop(cfg_drop), .cfg_ip(cfg_ip), .cfg_mask(cfg_mask), .busy(busy),
    .dec_valid(dec_valid), .dec_drop(dec_drop), .dec_hit(dec_hit), .dec_idx(dec_idx),
    .missed_cnt(missed_cnt), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic hit;
    logic drop;
    int   idx;
    int   cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_dec = 0;
  int   exp_pkts = 0;
  int   exp_drops = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (dec_valid === 1'b1) begin
      n_dec++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_dec: got dec_valid at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("dec_cycle", 64'(cyc), 64'(e.cyc));
        check("dec_hit", 64'(dec_hit), 64'(e.hit));
        check("dec_drop", 64'(dec_drop), 64'(e.drop));
        check("dec_idx", 64'(dec_idx), 64'(e.idx));
      end
    end
  end

  task automatic expect_dec(input logic hit, input logic drop, input int idx, input int c);
    exp_t e;
    e.hit = hit; e.drop = drop; e.idx = idx; e.cyc = c;
    exp_q.push_back(e);
    exp_pkts++;
    if (drop) exp_drops++;
  endtask

  task automatic write_rule(input int idx, input logic en, input logic dir, input logic drop,
                            input logic [31:0] ip, input logic [31:0] mask);
    cfg_we = 1'b1; cfg_addr = 4'(idx); cfg_en = en; cfg_dir = dir;
    cfg_drop = drop; cfg_ip = ip; cfg_mask = mask;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Returns the trigger cycle T; ip_valid is high for exactly that cycle.
  task automatic trigger(input logic [31:0] s, input logic [31:0] d, output int t);
    src_ip = s; dst_ip = d; ip_valid = 1'b1; t = cyc;
    @(posedge clk); #1;
    ip_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int i;
    for (i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (!busy && exp_q.size() == 0) break;
    end
    if (i == 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got busy=%0d pending=%0d expected idle", name, busy, exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  int t;
  int d0;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_busy", 64'(busy), 64'd0);
    check("rst_dec_valid", 64'(dec_valid), 64'd0);
    check("rst_dec_hit", 64'(dec_hit), 64'd0);
    check("rst_dec_drop", 64'(dec_drop), 64'd0);
    check("rst_dec_idx", 64'(dec_idx), 64'd0);
    check("rst_missed", 64'(missed_cnt), 64'd0);
    check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);

    // Full miss with all rules disabled: decision at T+17, default drop
    trigger(32'h0A000005, 32'hC0A80109, t);
    expect_dec(1'b0, 1'b1, 0, t + 17);
    wait_done("miss");

    // Exact /32 hit on rule 3; inputs change after trigger and must not matter
    write_rule(3, 1'b1, 1'b0, 1'b1, 32'h0A000005, 32'hFFFFFFFF);
    trigger(32'h0A000005, 32'h0, t);
    src_ip = 32'h0A000006;
    expect_dec(1'b1, 1'b1, 3, t + 5);
    wait_done("exact");

    // Prefix + priority on dst: /16 allow at 1 beats /24 drop at 2
    write_rule(1, 1'b1, 1'b1, 1'b0, 32'hC0A80000, 32'hFFFF0000);
    write_rule(2, 1'b1, 1'b1, 1'b1, 32'hC0A80100, 32'hFFFFFF00);
    trigger(32'h0, 32'hC0A80109, t);
    expect_dec(1'b1, 1'b0, 1, t + 3);
    wait_done("prio");
    repeat (3) @(posedge clk);
    #1;
    check("hold_idx", 64'(dec_idx), 64'd1);
    check("hold_hit", 64'(dec_hit), 64'd1);
    check("hold_drop", 64'(dec_drop), 64'd0);

    write_rule(1, 1'b0, 1'b1, 1'b0, 32'hC0A80000, 32'hFFFF0000);
    trigger(32'h0, 32'hC0A80109, t);
    expect_dec(1'b1, 1'b1, 2, t + 4);
    wait_done("prefix24");

    // Mask 0 matches anything
    write_rule(5, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0);
    trigger(32'h01020304, 32'h0, t);
    expect_dec(1'b1, 1'b0, 5, t + 7);
    wait_done("mask0");

    // Second rising edge 3 cycles into a lookup is dropped and counted
    d0 = n_dec;
    trigger(32'h0A000005, 32'h0, t);
    expect_dec(1'b1, 1'b1, 3, t + 5);
    @(posedge clk); #1;
    ip_valid = 1'b1;
    @(posedge clk); #1;
    ip_valid = 1'b0;
    wait_done("collision");
    repeat (3) @(posedge clk);
    #1;
    check("collision_missed", 64'(missed_cnt), 64'd1);
    check("collision_pulses", 64'(n_dec - d0), 64'd1);

    // Held-high ip_valid triggers once
    d0 = n_dec;
    src_ip = 32'h0A000005; dst_ip = 32'h0; ip_valid = 1'b1; t = cyc;
    expect_dec(1'b1, 1'b1, 3, t + 5);
    repeat (40) @(posedge clk);
    #1 ip_valid = 1'b0;
    wait_done("held");
    check("held_pulses", 64'(n_dec - d0), 64'd1);
    check("held_missed", 64'(missed_cnt), 64'd1);

    // A write landing mid-scan is visible to a later index
    write_rule(5, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0);
    trigger(32'h0B000001, 32'h0, t);
    write_rule(7, 1'b1, 1'b0, 1'b1, 32'h0B000001, 32'hFFFFFFFF);
    expect_dec(1'b1, 1'b1, 7, t + 9);
    wait_done("midwrite");

`ifdef IP_RULE_STATS_EN
    check("pkt_cnt", 64'(pkt_cnt), 64'(exp_pkts));
    check("drop_cnt", 64'(drop_cnt), 64'(exp_drops));
`else
    check("pkt_cnt_off", 64'(pkt_cnt), 64'd0);
    check("drop_cnt_off", 64'(drop_cnt), 64'd0);
`endif

    // Reset at T+4 of a miss lookup aborts it with no pulse
    d0 = n_dec;
    trigger(32'h7F000001, 32'h0, t);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_missed", 64'(missed_cnt), 64'd0);
    check("midrst_hit", 64'(dec_hit), 64'd0);
    check("midrst_pkt", 64'(pkt_cnt), 64'd0);
    repeat (20) @(posedge clk);
    #1;
    check("midrst_pulses", 64'(n_dec - d0), 64'd0);

    // Rule 3 would hit if its enable had survived reset
    trigger(32'h0A000005, 32'hC0A80109, t);
    expect_dec(1'b0, 1'b1, 0, t + 17);
    wait_done("postrst");

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
